// File: rtl/present80_key_schedule_if.sv
// Handshake bundle between the PRESENT-80 key schedule and its controller/consumer.
// The controller side (master) drives load/key_in/dec/rk_ready; the schedule (slave) drives the rest.
`timescale 1ns/1ps
interface present80_key_schedule_if;
  logic        load;
  logic [79:0] key_in;
  logic        dec;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [63:0] rk_out;
  logic [4:0]  rk_idx;
  logic        done;

  modport master (
    output load, key_in, dec, rk_ready,
    input  busy, rk_valid, rk_out, rk_idx, done
  );

  modport slave (
    input  load, key_in, dec, rk_ready,
    output busy, rk_valid, rk_out, rk_idx, done
  );
endinterface

// File: rtl/present80_key_schedule.sv
// Sequential PRESENT-80 key schedule: loads an 80-bit key and streams K1..K32 over valid/ready.
// Optional macro PRESENT_KS_DEC_EN adds reverse-order (K32..K1) output for decryption.
`timescale 1ns/1ps
module present_sbox4 (
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);
  always_comb begin
    o_y = 4'h0;
    case (i_x)
      4'h0: o_y = 4'hC;  4'h1: o_y = 4'h5;  4'h2: o_y = 4'h6;  4'h3: o_y = 4'hB;
      4'h4: o_y = 4'h9;  4'h5: o_y = 4'h0;  4'h6: o_y = 4'hA;  4'h7: o_y = 4'hD;
      4'h8: o_y = 4'h3;  4'h9: o_y = 4'hE;  4'hA: o_y = 4'hF;  4'hB: o_y = 4'h8;
      4'hC: o_y = 4'h4;  4'hD: o_y = 4'h7;  4'hE: o_y = 4'h1;  default: o_y = 4'h2;
    endcase
  end
endmodule

module present80_key_schedule #(
  parameter int NUM_ROUNDS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  present80_key_schedule_if.slave  ks
);
  localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_PRECOMP} state_t;

  state_t      r_state;
  logic [79:0] r_key;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_rk_valid;
  logic        r_done;

  // Forward update for round counter cnt+1: rotate left 61, S-box top nibble, XOR counter.
  logic [79:0] w_rot;
  logic [3:0]  w_sb;
  logic [4:0]  w_rnd;
  logic [79:0] w_fwd;

  assign w_rot = {r_key[18:0], r_key[79:19]};
  assign w_rnd = r_cnt + 5'd1;
  assign w_fwd = {w_sb, w_rot[75:20], w_rot[19:15] ^ w_rnd, w_rot[14:0]};

  present_sbox4 u_sbox (
    .i_x (w_rot[79:76]),
    .o_y (w_sb)
  );

`ifdef PRESENT_KS_DEC_EN
  logic        r_dec;
  logic [79:0] w_xr;
  logic [79:0] w_pre;
  logic [79:0] w_inv;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
    endcase
  endfunction

  // Undo the forward step that produced the key at index cnt: XOR, inverse S-box, rotate right 61.
  assign w_xr  = {r_key[79:20], r_key[19:15] ^ r_cnt, r_key[14:0]};
  assign w_pre = {inv_sbox(w_xr[79:76]), w_xr[75:0]};
  assign w_inv = {w_pre[60:0], w_pre[79:61]};
`else
  logic w_unused_dec;
  assign w_unused_dec = ks.dec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
`ifdef PRESENT_KS_DEC_EN
      r_dec      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ks.load) begin
            r_key  <= ks.key_in;
            r_cnt  <= '0;
            r_busy <= 1'b1;
`ifdef PRESENT_KS_DEC_EN
            r_dec  <= ks.dec;
            if (ks.dec) begin
              r_state <= S_PRECOMP;
            end else begin
              r_state    <= S_EMIT;
              r_rk_valid <= 1'b1;
            end
`else
            r_state    <= S_EMIT;
            r_rk_valid <= 1'b1;
`endif
          end
        end
`ifdef PRESENT_KS_DEC_EN
        // Walk forward to K32 before streaming backwards.
        S_PRECOMP: begin
          r_key <= w_fwd;
          r_cnt <= w_rnd;
          if (r_cnt == LAST - 5'd1) begin
            r_state    <= S_EMIT;
            r_rk_valid <= 1'b1;
          end
        end
`endif
        S_EMIT: begin
          if (ks.rk_ready) begin
`ifdef PRESENT_KS_DEC_EN
            if (r_dec ? (r_cnt == 5'd0) : (r_cnt == LAST)) begin
              r_state    <= S_IDLE;
              r_rk_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else if (r_dec) begin
              r_key <= w_inv;
              r_cnt <= r_cnt - 5'd1;
            end else begin
              r_key <= w_fwd;
              r_cnt <= w_rnd;
            end
`else
            if (r_cnt == LAST) begin
              r_state    <= S_IDLE;
              r_rk_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_key <= w_fwd;
              r_cnt <= w_rnd;
            end
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ks.busy     = r_busy;
  assign ks.rk_valid = r_rk_valid;
  assign ks.rk_out   = r_key[79:16];
  assign ks.rk_idx   = r_cnt;
  assign ks.done     = r_done;
endmodule
